// File: rtl/tdm_pkg.sv
// Shared constants and state type for the 4-slot TDM receive demultiplexer.
package tdm_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        HUNT,
        RUN
    } tdm_state_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// Link-side and frame-side signals of the TDM demultiplexer, bundled with modports.
interface tdm_demux4_if
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) ();

    logic [WIDTH-1:0]        in_data;
    logic                    in_valid;
    logic                    in_sof;
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic                    out_valid;
    logic [SEL_W-1:0]        sel;
    logic                    sync_err;

    modport master (
        output in_data, in_valid, in_sof,
        input  out_data, out_valid, sel, sync_err
    );

    modport slave (
        input  in_data, in_valid, in_sof,
        output out_data, out_valid, sel, sync_err
    );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Mod-4 slot counter: clear beats load-to-1, which beats increment.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             clr_i,
    output logic [SEL_W-1:0] cnt_o
);

    logic [SEL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = SEL_W'(1);
        end else if (en_i) begin
            cnt_d = cnt_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM receiver: aligns on start-of-frame, collects slots 0..2 in shadow
// registers and publishes a whole frame when the slot-3 sample arrives.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    tdm_demux4_if.slave  bus
);

    tdm_state_t                        state_q, state_d;
    logic [NUM_CH-2:0][WIDTH-1:0]      shadow_q, shadow_d;
    logic [NUM_CH*WIDTH-1:0]           out_data_q, out_data_d;
    logic                              out_valid_q, out_valid_d;
    logic                              sync_err_q, sync_err_d;
    logic                              ctr_en, ctr_load, ctr_clr;
    logic [SEL_W-1:0]                  sel;

    tdm_slot_ctr u_slot_ctr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (ctr_en),
        .load_i (ctr_load),
        .clr_i  (ctr_clr),
        .cnt_o  (sel)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        shadow_d    = shadow_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;
        ctr_en      = 1'b0;
        ctr_load    = 1'b0;
        ctr_clr     = 1'b0;

        if (bus.in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.in_sof) begin
                        shadow_d[0] = bus.in_data;
                        ctr_load    = 1'b1;
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (bus.in_sof) begin
                        // An early sof drops the partial frame and restarts at slot 0.
                        sync_err_d  = (sel != '0);
                        shadow_d[0] = bus.in_data;
                        ctr_load    = 1'b1;
                    end else begin
                        unique case (sel)
                            2'd0: begin
                                sync_err_d = 1'b1;
                                ctr_clr    = 1'b1;
                                state_d    = HUNT;
                            end
                            2'd1: begin
                                shadow_d[1] = bus.in_data;
                                ctr_en      = 1'b1;
                            end
                            2'd2: begin
                                shadow_d[2] = bus.in_data;
                                ctr_en      = 1'b1;
                            end
                            default: begin
                                out_data_d  = {bus.in_data, shadow_q[2], shadow_q[1], shadow_q[0]};
                                out_valid_d = 1'b1;
                                ctr_en      = 1'b1;
                            end
                        endcase
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the same pre-edge values.
        if (rst) begin
            // NOTE: the shadow slots are plain flops, not a memory, so they take the reset too.
            state_q     <= HUNT;
            shadow_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sync_err  = sync_err_q;
    assign bus.sel       = sel;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: a WIDTH=1 instance for the main scenarios and a
// WIDTH=8 instance for the wide-channel frame.
module tb_tdm_demux4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int ov_cnt = 0;
    int se_cnt = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    tdm_demux4_if #(.WIDTH(1)) b0 ();
    tdm_demux4_if #(.WIDTH(8)) b8 ();

    tdm_demux4 #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b0.slave));
    tdm_demux4 #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8.slave));

    // Pulse monitor on the narrow instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (b0.out_valid === 1'b1) ov_cnt++;
        if (b0.sync_err === 1'b1) se_cnt++;
        if (b0.out_valid === 1'b1 && b0.sync_err === 1'b1) both_cnt++;
    end

    // Drive one cycle on the narrow link; returns 1 ns after the edge.
    task automatic send(input logic v, input logic sof, input logic d);
        b0.in_valid = v;
        b0.in_sof   = sof;
        b0.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic v, input logic sof, input logic [7:0] d);
        b8.in_valid = v;
        b8.in_sof   = sof;
        b8.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) send(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        pulse_reset(2);
        n_cmp++; if (b0.out_data !== 4'b0000) begin n_err++; $display("FAIL reset_out_data: got %b want 0000", b0.out_data); end
        n_cmp++; if (b0.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", b0.out_valid); end
        n_cmp++; if (b0.sel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", b0.sel); end
        n_cmp++; if (b0.sync_err !== 1'b0) begin n_err++; $display("FAIL reset_sync_err: got %b want 0", b0.sync_err); end
        n_cmp++; if (b8.out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data8: got %h want 00000000", b8.out_data); end
    endtask

    task automatic test_frame;
        logic [1:0] exp_sel [4];
        logic       smp [4];
        exp_sel = '{2'd1, 2'd2, 2'd3, 2'd0};
        smp     = '{1'b1, 1'b0, 1'b1, 1'b1};
        ov_cnt = 0; se_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, (i == 0), smp[i]);
            n_cmp++; if (b0.sel !== exp_sel[i]) begin n_err++; $display("FAIL frame_sel%0d: got %0d want %0d", i, b0.sel, exp_sel[i]); end
        end
        n_cmp++; if (b0.out_valid !== 1'b1) begin n_err++; $display("FAIL frame_out_valid: got %b want 1", b0.out_valid); end
        n_cmp++; if (b0.out_data !== 4'b1101) begin n_err++; $display("FAIL frame_out_data: got %b want 1101", b0.out_data); end
        send(1'b0, 1'b0, 1'b0);
        n_cmp++; if (b0.out_valid !== 1'b0) begin n_err++; $display("FAIL frame_pulse_end: got %b want 0", b0.out_valid); end
        n_cmp++; if (b0.out_data !== 4'b1101) begin n_err++; $display("FAIL frame_hold: got %b want 1101", b0.out_data); end
        n_cmp++; if (ov_cnt !== 1 || se_cnt !== 0) begin n_err++; $display("FAIL frame_pulses: got ov=%0d se=%0d want ov=1 se=0", ov_cnt, se_cnt); end
    endtask

    task automatic test_gaps;
        logic [1:0] exp_sel [4];
        logic       smp [4];
        exp_sel = '{2'd1, 2'd2, 2'd3, 2'd0};
        smp     = '{1'b1, 1'b0, 1'b1, 1'b1};
        pulse_reset(1);
        ov_cnt = 0; se_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, (i == 0), smp[i]);
            n_cmp++; if (b0.sel !== exp_sel[i]) begin n_err++; $display("FAIL gaps_sel%0d: got %0d want %0d", i, b0.sel, exp_sel[i]); end
            // in_sof without in_valid during the gap must not disturb alignment.
            send(1'b0, 1'b1, 1'b1);
            send(1'b0, 1'b0, 1'b0);
            send(1'b0, 1'b0, 1'b0);
            n_cmp++; if (b0.sel !== exp_sel[i]) begin n_err++; $display("FAIL gaps_hold_sel%0d: got %0d want %0d", i, b0.sel, exp_sel[i]); end
        end
        n_cmp++; if (b0.out_data !== 4'b1101) begin n_err++; $display("FAIL gaps_out_data: got %b want 1101", b0.out_data); end
        n_cmp++; if (ov_cnt !== 1 || se_cnt !== 0) begin n_err++; $display("FAIL gaps_pulses: got ov=%0d se=%0d want ov=1 se=0", ov_cnt, se_cnt); end
    endtask

    task automatic test_resync;
        ov_cnt = 0; se_cnt = 0;
        send(1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        n_cmp++; if (b0.sync_err !== 1'b1) begin n_err++; $display("FAIL resync_err: got %b want 1", b0.sync_err); end
        n_cmp++; if (b0.out_valid !== 1'b0) begin n_err++; $display("FAIL resync_no_valid: got %b want 0", b0.out_valid); end
        n_cmp++; if (b0.sel !== 2'd1) begin n_err++; $display("FAIL resync_sel: got %0d want 1", b0.sel); end
        send(1'b1, 1'b0, 1'b1);
        n_cmp++; if (b0.sync_err !== 1'b0) begin n_err++; $display("FAIL resync_err_pulse: got %b want 0", b0.sync_err); end
        send(1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b0);
        n_cmp++; if (b0.out_valid !== 1'b1) begin n_err++; $display("FAIL resync_valid: got %b want 1", b0.out_valid); end
        n_cmp++; if (b0.out_data !== 4'b0110) begin n_err++; $display("FAIL resync_out_data: got %b want 0110", b0.out_data); end
        send(1'b0, 1'b0, 1'b0);
        n_cmp++; if (ov_cnt !== 1 || se_cnt !== 1) begin n_err++; $display("FAIL resync_pulses: got ov=%0d se=%0d want ov=1 se=1", ov_cnt, se_cnt); end
    endtask

    task automatic test_missing_sof;
        // Fifth sample with no sof after a full frame: dropped, error, back to HUNT.
        se_cnt = 0;
        send(1'b1, 1'b0, 1'b1);
        n_cmp++; if (b0.sync_err !== 1'b1) begin n_err++; $display("FAIL nosof_err: got %b want 1", b0.sync_err); end
        send(1'b1, 1'b0, 1'b1);
        n_cmp++; if (b0.sel !== 2'd0 || b0.sync_err !== 1'b0) begin n_err++; $display("FAIL nosof_hunt: got sel=%0d err=%b want sel=0 err=0", b0.sel, b0.sync_err); end
        send(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_hunt;
        logic       smp [4];
        logic [7:0] wide [4];
        smp  = '{1'b0, 1'b0, 1'b0, 1'b1};
        wide = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
        pulse_reset(1);
        ov_cnt = 0; se_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0, 1'b1);
            n_cmp++; if (b0.sel !== 2'd0) begin n_err++; $display("FAIL hunt_sel%0d: got %0d want 0", i, b0.sel); end
        end
        n_cmp++; if (ov_cnt !== 0 || se_cnt !== 0 || b0.out_data !== 4'b0000) begin n_err++; $display("FAIL hunt_idle: got ov=%0d se=%0d data=%b want 0 0 0000", ov_cnt, se_cnt, b0.out_data); end
        for (int i = 0; i < 4; i++) send(1'b1, (i == 0), smp[i]);
        n_cmp++; if (b0.out_valid !== 1'b1 || b0.out_data !== 4'b1000) begin n_err++; $display("FAIL hunt_frame: got v=%b data=%b want v=1 data=1000", b0.out_valid, b0.out_data); end
        send(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send8(1'b1, (i == 0), wide[i]);
        n_cmp++; if (b8.out_valid !== 1'b1 || b8.out_data !== 32'h01FF3CA5) begin n_err++; $display("FAIL wide_frame: got v=%b data=%h want v=1 data=01ff3ca5", b8.out_valid, b8.out_data); end
        send8(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid_frame;
        logic smp [4];
        smp = '{1'b0, 1'b1, 1'b0, 1'b1};
        send(1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        pulse_reset(1);
        n_cmp++; if (b0.sel !== 2'd0) begin n_err++; $display("FAIL rstmid_sel: got %0d want 0", b0.sel); end
        ov_cnt = 0; se_cnt = 0;
        for (int i = 0; i < 4; i++) send(1'b1, (i == 0), smp[i]);
        n_cmp++; if (b0.out_data !== 4'b1010) begin n_err++; $display("FAIL rstmid_out_data: got %b want 1010", b0.out_data); end
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        n_cmp++; if (ov_cnt !== 1 || se_cnt !== 0) begin n_err++; $display("FAIL rstmid_pulses: got ov=%0d se=%0d want ov=1 se=0", ov_cnt, se_cnt); end
    endtask

    initial begin
        b0.in_valid = 1'b0; b0.in_sof = 1'b0; b0.in_data = '0;
        b8.in_valid = 1'b0; b8.in_sof = 1'b0; b8.in_data = '0;
        test_reset();
        test_frame();
        test_gaps();
        test_resync();
        test_missing_sof();
        test_hunt();
        test_reset_mid_frame();
        n_cmp++; if (both_cnt !== 0) begin n_err++; $display("FAIL valid_err_overlap: got %0d want 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
